// File: rtl/rr_arbiter_onehot_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkg
// Brief   : Shared types for the one-hot round-robin arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Arbitration policy: fixed highest-index priority or rotating priority
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_onehot_if.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter_onehot_if
// Brief   : Request/grant bundle between requesters and the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface rr_arbiter_onehot_if #(
  parameter int N = 8
) ();

  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;

  // Requester side drives requests and observes the grant
  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_idx
  );

  // Arbiter side consumes requests and produces the grant
  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_idx
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter_onehot_pe.sv
`default_nettype none
// ============================================================================
// Module  : pe_onehot_n
// Brief   : Combinational MSB-first one-hot priority encoder, N bits wide.
//           Bit i survives only when no higher-index bit is set.
// Revision: 1.0 - initial release
// ============================================================================
module pe_onehot_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  logic [N-1:0] higher_any;

  // Running OR of all bits above position i, walked from the MSB down
  always_comb begin
    higher_any = '0;
    for (int i = N - 2; i >= 0; i--) begin
      higher_any[i] = higher_any[i+1] | a[i+1];
    end
  end

  assign y = a & ~higher_any;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_onehot.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter_onehot
// Brief   : N-way arbiter with registered one-hot grant, fixed or rotating
//           priority, and optional grant hold while the winner keeps
//           requesting. All outputs are registered.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter_onehot
  import arb_pkg::*;
#(
  parameter int        N    = 8,
  parameter arb_mode_e MODE = ARB_RR,
  parameter bit        HOLD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_arbiter_onehot_if.slave   bus
);

  localparam int IW = $clog2(N);

  logic [N-1:0]  grant_q, grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  req;
  logic [N-1:0]  below_ptr;
  logic [N-1:0]  masked;
  logic [N-1:0]  pick_masked;
  logic [N-1:0]  pick_full;
  logic [N-1:0]  arb;
  logic [IW-1:0] arb_idx;
  logic          hold_hit;

  assign req = bus.req;

  // Thermometer mask of positions strictly below the last winner
  always_comb begin
    below_ptr = '0;
    for (int i = 0; i < N; i++) begin
      below_ptr[i] = (i < int'(ptr_q));
    end
  end

  // Fixed mode never consults the pointer, so the masked path stays empty
  assign masked = (MODE == ARB_RR) ? (req & below_ptr) : '0;

  pe_onehot_n #(.N(N)) u_pe_masked (
    .a (masked),
    .y (pick_masked)
  );

  pe_onehot_n #(.N(N)) u_pe_full (
    .a (req),
    .y (pick_full)
  );

  assign arb = (|masked) ? pick_masked : pick_full;

  // Binary index of the fresh arbitration result (zero when nobody wins)
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (arb[i]) begin
        arb_idx = arb_idx | IW'(i);
      end
    end
  end

  // Next-state: keep the current owner while it still requests, else re-arbitrate
  always_comb begin
    hold_hit      = HOLD && (|(grant_q & req));
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
    if (!hold_hit) begin
      grant_d       = arb;
      grant_idx_d   = arb_idx;
      grant_valid_d = |arb;
      if (|arb) begin
        ptr_d = arb_idx;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      ptr_q         <= '0;
    end else begin
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      ptr_q         <= ptr_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_onehot.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_arbiter_onehot
// Brief   : Self-checking bench for rr_arbiter_onehot across several
//           N/MODE/HOLD configurations sharing one request bus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_onehot;
  import arb_pkg::*;

  localparam int ND = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;

  int errors = 0;
  int checks = 0;

  // DUT configuration table: index -> N, MODE (0 fixed / 1 rr), HOLD
  int c_n    [ND] = '{8, 8, 8, 5, 16, 2, 5};
  int c_mode [ND] = '{0, 1, 1, 1, 0, 1, 0};
  int c_hold [ND] = '{0, 0, 1, 1, 1, 0, 0};

  logic [15:0] obs_g [ND];
  logic [3:0]  obs_i [ND];
  logic        obs_v [ND];

  logic [15:0] m_g   [ND];
  int          m_ptr [ND];

  always #5 clk = ~clk;

  rr_arbiter_onehot_if #(.N(8))  if0 ();
  rr_arbiter_onehot_if #(.N(8))  if1 ();
  rr_arbiter_onehot_if #(.N(8))  if2 ();
  rr_arbiter_onehot_if #(.N(5))  if3 ();
  rr_arbiter_onehot_if #(.N(16)) if4 ();
  rr_arbiter_onehot_if #(.N(2))  if5 ();
  rr_arbiter_onehot_if #(.N(5))  if6 ();

  assign if0.req = req[7:0];
  assign if1.req = req[7:0];
  assign if2.req = req[7:0];
  assign if3.req = req[4:0];
  assign if4.req = req[15:0];
  assign if5.req = req[1:0];
  assign if6.req = req[4:0];

  rr_arbiter_onehot #(.N(8),  .MODE(ARB_FIXED), .HOLD(1'b0)) d0 (.clk(clk), .rst(rst), .bus(if0));
  rr_arbiter_onehot #(.N(8),  .MODE(ARB_RR),    .HOLD(1'b0)) d1 (.clk(clk), .rst(rst), .bus(if1));
  rr_arbiter_onehot #(.N(8),  .MODE(ARB_RR),    .HOLD(1'b1)) d2 (.clk(clk), .rst(rst), .bus(if2));
  rr_arbiter_onehot #(.N(5),  .MODE(ARB_RR),    .HOLD(1'b1)) d3 (.clk(clk), .rst(rst), .bus(if3));
  rr_arbiter_onehot #(.N(16), .MODE(ARB_FIXED), .HOLD(1'b1)) d4 (.clk(clk), .rst(rst), .bus(if4));
  rr_arbiter_onehot #(.N(2),  .MODE(ARB_RR),    .HOLD(1'b0)) d5 (.clk(clk), .rst(rst), .bus(if5));
  rr_arbiter_onehot #(.N(5),  .MODE(ARB_FIXED), .HOLD(1'b0)) d6 (.clk(clk), .rst(rst), .bus(if6));

  assign obs_g[0] = 16'(if0.grant); assign obs_i[0] = 4'(if0.grant_idx); assign obs_v[0] = if0.grant_valid;
  assign obs_g[1] = 16'(if1.grant); assign obs_i[1] = 4'(if1.grant_idx); assign obs_v[1] = if1.grant_valid;
  assign obs_g[2] = 16'(if2.grant); assign obs_i[2] = 4'(if2.grant_idx); assign obs_v[2] = if2.grant_valid;
  assign obs_g[3] = 16'(if3.grant); assign obs_i[3] = 4'(if3.grant_idx); assign obs_v[3] = if3.grant_valid;
  assign obs_g[4] = 16'(if4.grant); assign obs_i[4] = 4'(if4.grant_idx); assign obs_v[4] = if4.grant_valid;
  assign obs_g[5] = 16'(if5.grant); assign obs_i[5] = 4'(if5.grant_idx); assign obs_v[5] = if5.grant_valid;
  assign obs_g[6] = 16'(if6.grant); assign obs_i[6] = 4'(if6.grant_idx); assign obs_v[6] = if6.grant_valid;

  // Single comparison point: counts every check and reports mismatches
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges
  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  function automatic int oh_to_idx(input logic [15:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Reference arbiter: one clock edge of behaviour for one configuration
  task automatic model_step(input int n, input int mode, input int hold,
                            input logic [15:0] rq,
                            input logic [15:0] g_in, input int p_in,
                            output logic [15:0] g_out, output int p_out);
    logic [15:0] rqm;
    int w;
    rqm = '0;
    for (int i = 0; i < n; i++) rqm[i] = rq[i];
    g_out = g_in;
    p_out = p_in;
    if (!(hold != 0 && (g_in & rqm) != 0)) begin
      w = -1;
      if (mode != 0) begin
        for (int i = p_in - 1; i >= 0 && w < 0; i--) if (rqm[i]) w = i;
      end
      if (w < 0) begin
        for (int i = n - 1; i >= 0 && w < 0; i--) if (rqm[i]) w = i;
      end
      if (w >= 0) begin
        g_out = 16'd1 << w;
        p_out = w;
      end else begin
        g_out = '0;
      end
    end
  endtask

  initial begin
    logic [15:0] ng;
    int np;
    int e;

    rst = 1'b1;
    req = '0;
    #12;
    chk("reset grant",       32'(obs_g[1]), 32'h0);
    chk("reset grant_valid", 32'(obs_v[1]), 32'h0);
    chk("reset grant_idx",   32'(obs_i[1]), 32'h0);
    rst = 1'b0;

    // Fixed priority: highest index wins, one cycle latency
    req = 16'h002C;
    tick();
    chk("fixed grant", 32'(obs_g[0]), 32'h20);
    chk("fixed idx",   32'(obs_i[0]), 32'd5);
    chk("fixed valid", 32'(obs_v[0]), 32'd1);

    // Round-robin rotation with all requesting
    do_reset();
    req = 16'h00FF;
    for (int k = 0; k < 9; k++) begin
      tick();
      e = (k == 8) ? 7 : 7 - k;
      chk($sformatf("rr rotate idx k=%0d", k), 32'(obs_i[1]), 32'(e));
      chk($sformatf("rr rotate grant k=%0d", k), 32'(obs_g[1]), 32'd1 << e);
    end

    // Wrap between bits 0 and 7
    do_reset();
    req = 16'h00FF;
    tick();
    chk("wrap first idx", 32'(obs_i[1]), 32'd7);
    req = 16'h0081;
    tick();
    chk("wrap idx0 a", 32'(obs_i[1]), 32'd0);
    tick();
    chk("wrap idx7",   32'(obs_i[1]), 32'd7);
    tick();
    chk("wrap idx0 b", 32'(obs_i[1]), 32'd0);

    // Sole requester granted every cycle, then idle
    req = 16'h0004;
    tick();
    chk("sole idx a", 32'(obs_i[1]), 32'd2);
    tick();
    chk("sole idx b", 32'(obs_i[1]), 32'd2);
    req = 16'h0000;
    tick();
    chk("idle grant", 32'(obs_g[1]), 32'h0);
    chk("idle valid", 32'(obs_v[1]), 32'h0);
    chk("idle idx",   32'(obs_i[1]), 32'h0);
    // Pointer retained through idle: bit 1 is below ptr=2, so it beats bit 3
    req = 16'h000A;
    tick();
    chk("ptr kept idx", 32'(obs_i[1]), 32'd1);

    // Hold: owner keeps grant while requesting, handoff without a bubble
    do_reset();
    req = 16'h0060;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold idx k=%0d", k), 32'(obs_i[2]), 32'd6);
    end
    req = 16'h0020;
    tick();
    chk("handoff idx",   32'(obs_i[2]), 32'd5);
    chk("handoff valid", 32'(obs_v[2]), 32'd1);
    req = 16'h00FF;
    tick();
    chk("hold vs higher idx", 32'(obs_i[2]), 32'd5);

    // Asynchronous reset mid-hold takes effect without a clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("async rst grant", 32'(obs_g[2]), 32'h0);
    chk("async rst valid", 32'(obs_v[2]), 32'h0);
    chk("async rst idx",   32'(obs_i[2]), 32'h0);
    chk("async rst rr grant", 32'(obs_g[1]), 32'h0);
    req = 16'h000A;
    rst = 1'b0;
    tick();
    chk("post rst idx",    32'(obs_i[2]), 32'd3);
    chk("post rst rr idx", 32'(obs_i[1]), 32'd3);

    // Random traffic against the reference model for every configuration
    do_reset();
    for (int k = 0; k < ND; k++) begin
      m_g[k]   = '0;
      m_ptr[k] = 0;
    end
    req = 16'(($urandom() & 32'hFFFF));
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 19) == 0) req = '0;
      else req = req ^ 16'($urandom() & $urandom());
      tick();
      for (int k = 0; k < ND; k++) begin
        model_step(c_n[k], c_mode[k], c_hold[k], req, m_g[k], m_ptr[k], ng, np);
        m_g[k]   = ng;
        m_ptr[k] = np;
        chk($sformatf("rand c%0d d%0d grant", c, k), 32'(obs_g[k]), 32'(m_g[k]));
        chk($sformatf("rand c%0d d%0d idx", c, k),   32'(obs_i[k]), 32'(oh_to_idx(m_g[k])));
        chk($sformatf("rand c%0d d%0d valid", c, k), 32'(obs_v[k]), 32'(m_g[k] != 0));
        chk($sformatf("rand c%0d d%0d onehot0", c, k), 32'($onehot0(obs_g[k])), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
